// File: rtl/l1a_sched_pkg.sv
// Shared constants and helpers for the L1A trigger scheduler.
package l1a_sched_pkg;

    localparam int NREQ     = 3;
    localparam int SRC_W    = 2;
    localparam int SRC_EXT  = 0;
    localparam int SRC_RAN  = 1;
    localparam int SRC_JTAG = 2;
    localparam int CNT_W    = 16;

    function automatic logic [CNT_W-1:0] vote3(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b,
                                               input logic [CNT_W-1:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic logic [1:0] popcount3(input logic [NREQ-1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

endpackage

// File: rtl/l1a_window_cnt.sv
// Trigger-rule tracker: L1A history shift register plus a running count of
// L1As in the last WIN-1 cycles; says whether a grant is allowed this cycle.
module l1a_window_cnt #(
    parameter int WIN    = 25,
    parameter int MAXWIN = 2,
    parameter int GAP    = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic fire,
    output logic ok
);

    // hist[k] mirrors the L1A output k cycles ago (hist[0] == current L1A)
    localparam int DEPTH = (WIN - 1 > GAP - 1) ? WIN - 1 : GAP - 1;
    localparam int CW    = $clog2(WIN + 1);
    localparam logic [DEPTH-1:0] SPACE_MASK = (DEPTH'(1) << (GAP - 1)) - DEPTH'(1);

    logic [DEPTH-1:0] hist;
    logic [CW-1:0]    cnt;
    logic             space_ok;
    logic             win_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            hist <= '0;
            cnt  <= '0;
        end else begin
            hist <= (hist << 1) | DEPTH'(fire);
            // entering and leaving in the same cycle cancel out
            cnt  <= cnt + CW'(fire) - CW'(hist[WIN-2]);
        end
    end

    assign space_ok = ~|(hist & SPACE_MASK);
    assign win_ok   = (cnt < CW'(MAXWIN));
    assign ok       = space_ok & win_ok;

endmodule

// File: rtl/l1a_sched.sv
// Trigger scheduler: latches request pulses, grants by fixed priority under
// spacing/window rules, drops requests that wait too long, counts both.
module l1a_sched
    import l1a_sched_pkg::*;
#(
    parameter int TMR    = 0,
    parameter int WIN    = 25,
    parameter int MAXWIN = 2,
    parameter int GAP    = 2,
    parameter int HOLD   = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ENABLE,
    input  logic [NREQ-1:0]   REQ,
    input  logic              CNT_CLR,
    output logic              L1A,
    output logic [SRC_W-1:0]  L1A_SRC,
    output logic [NREQ-1:0]   DROP,
    output logic [NREQ-1:0]   PEND,
    output logic [CNT_W-1:0]  L1A_CNT,
    output logic [CNT_W-1:0]  DROP_CNT
);

    localparam int AW = $clog2(HOLD + 1);

    logic                      grant_ok;
    logic                      fire;
    logic [SRC_W-1:0]          gnt_src;
    logic [NREQ-1:0]           gnt_vec;
    logic [NREQ-1:0]           pend_nxt;
    logic [NREQ-1:0]           drop_nxt;
    logic [NREQ-1:0][AW-1:0]   age_q;
    logic [NREQ-1:0][AW-1:0]   age_nxt;
    logic [CNT_W-1:0]          l1a_cnt_nxt;
    logic [CNT_W-1:0]          drop_cnt_nxt;
    logic [CNT_W:0]            drop_sum;

    l1a_window_cnt #(
        .WIN    (WIN),
        .MAXWIN (MAXWIN),
        .GAP    (GAP)
    ) u_window (
        .clk  (CLK),
        .rst  (RST),
        .fire (fire),
        .ok   (grant_ok)
    );

    // lowest pending index wins
    always_comb begin
        gnt_src = '0;
        gnt_vec = '0;
        fire    = ENABLE & (|PEND) & grant_ok;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (PEND[i]) gnt_src = SRC_W'(i);
        end
        if (fire) gnt_vec[gnt_src] = 1'b1;
    end

    // grant beats timeout; a request colliding with a live pending one is dropped
    always_comb begin
        pend_nxt = '0;
        drop_nxt = '0;
        age_nxt  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_vec[i]) begin
                pend_nxt[i] = REQ[i];
            end else if (PEND[i]) begin
                if (age_q[i] == AW'(HOLD - 1)) begin
                    drop_nxt[i] = 1'b1;
                end else begin
                    pend_nxt[i] = 1'b1;
                    age_nxt[i]  = age_q[i] + AW'(1);
                    drop_nxt[i] = REQ[i];
                end
            end else begin
                pend_nxt[i] = REQ[i];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            PEND    <= '0;
            age_q   <= '0;
            DROP    <= '0;
            L1A     <= 1'b0;
            L1A_SRC <= '0;
        end else begin
            PEND    <= pend_nxt;
            age_q   <= age_nxt;
            DROP    <= drop_nxt;
            L1A     <= fire;
            L1A_SRC <= fire ? gnt_src : '0;
        end
    end

    assign drop_sum     = {1'b0, DROP_CNT} + (CNT_W + 1)'(popcount3(DROP));
    assign l1a_cnt_nxt  = CNT_CLR ? '0 : L1A_CNT + CNT_W'(L1A);
    assign drop_cnt_nxt = CNT_CLR ? '0 : (drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0]);

    generate
        if (TMR != 0) begin : g_tmr
            logic [2:0][CNT_W-1:0] l1a_cnt_r;
            logic [2:0][CNT_W-1:0] drop_cnt_r;

            always_ff @(posedge CLK) begin
                if (RST) begin
                    l1a_cnt_r  <= '0;
                    drop_cnt_r <= '0;
                end else begin
                    l1a_cnt_r  <= {3{l1a_cnt_nxt}};
                    drop_cnt_r <= {3{drop_cnt_nxt}};
                end
            end

            assign L1A_CNT  = vote3(l1a_cnt_r[0], l1a_cnt_r[1], l1a_cnt_r[2]);
            assign DROP_CNT = vote3(drop_cnt_r[0], drop_cnt_r[1], drop_cnt_r[2]);
        end else begin : g_plain
            logic [CNT_W-1:0] l1a_cnt_r;
            logic [CNT_W-1:0] drop_cnt_r;

            always_ff @(posedge CLK) begin
                if (RST) begin
                    l1a_cnt_r  <= '0;
                    drop_cnt_r <= '0;
                end else begin
                    l1a_cnt_r  <= l1a_cnt_nxt;
                    drop_cnt_r <= drop_cnt_nxt;
                end
            end

            assign L1A_CNT  = l1a_cnt_r;
            assign DROP_CNT = drop_cnt_r;
        end
    endgenerate

endmodule
